// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM, and latches the fetched word for decode.
// Redirects flush the fetch register. Misaligned redirect targets are masked and reported.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR = 32'h00000050
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        stall,
    input  logic        halt,
    input  logic        excpt,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        jump,
    input  logic [31:0] jtarget,
    input  logic        br_taken,
    input  logic [31:0] btarget,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid,
    output logic        addr_err,
    output logic [31:0] bad_addr,
    output logic [31:0] fetch_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt, w_tgt;
    logic        w_redir, w_capture, w_misal;
    logic        r_rom_ce, r_inst_valid, r_addr_err;
    logic [31:0] r_inst, r_pc_o, r_bad_addr, r_fetch_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt       = r_pc;
        w_redir     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_RUN;
            S_RUN: begin
                if (excpt) begin
                    w_redir = 1'b1;
                    w_tgt   = EXC_VECTOR;
                end else if (eret) begin
                    w_redir = 1'b1;
                    w_tgt   = epc;
                end else if (jump) begin
                    w_redir = 1'b1;
                    w_tgt   = jtarget;
                end else if (br_taken) begin
                    w_redir = 1'b1;
                    w_tgt   = btarget;
                end else if (halt) begin
                    w_state_nxt = S_HALT;
                end else if (!stall) begin
                    w_pc_nxt  = r_pc + 32'd4;
                    w_capture = 1'b1;
                end
            end
            S_HALT: begin
                // Only an exception can wake the fetch unit out of HALT.
                if (excpt) begin
                    w_redir     = 1'b1;
                    w_tgt       = EXC_VECTOR;
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_redir) w_pc_nxt = {w_tgt[31:2], 2'b00};
        w_misal = w_redir && (w_tgt[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_rom_ce     <= 1'b0;
            r_inst       <= '0;
            r_pc_o       <= '0;
            r_inst_valid <= 1'b0;
            r_addr_err   <= 1'b0;
            r_bad_addr   <= '0;
            r_fetch_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_rom_ce   <= (w_state_nxt == S_RUN);
            r_addr_err <= w_misal;
            if (w_misal) r_bad_addr <= w_tgt;
            // Stall leaves the fetch register untouched; redirect/halt only drop valid.
            if (w_capture) begin
                r_inst       <= rom_data;
                r_pc_o       <= r_pc;
                r_inst_valid <= 1'b1;
                r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            end else if (w_redir || w_state_nxt == S_HALT) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign rom_addr   = r_pc;
    assign rom_ce     = r_rom_ce;
    assign inst_o     = r_inst;
    assign pc_o       = r_pc_o;
    assign inst_valid = r_inst_valid;
    assign addr_err   = r_addr_err;
    assign bad_addr   = r_bad_addr;
    assign fetch_cnt  = r_fetch_cnt;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, sequential fetch, stall, redirects, misalignment,
// halt/wake, PC wrap and asynchronous reset.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_data;
    logic        stall = 0, halt = 0, excpt = 0, eret = 0, jump = 0, br_taken = 0;
    logic [31:0] epc = 0, jtarget = 0, btarget = 0;
    logic [31:0] inst_o, pc_o, bad_addr, fetch_cnt;
    logic        inst_valid, addr_err;
    int          nasrt = 0;
    int          nfail = 0;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
        .stall(stall), .halt(halt), .excpt(excpt), .eret(eret), .epc(epc),
        .jump(jump), .jtarget(jtarget), .br_taken(br_taken), .btarget(btarget),
        .inst_o(inst_o), .pc_o(pc_o), .inst_valid(inst_valid), .addr_err(addr_err),
        .bad_addr(bad_addr), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // ROM model: two fixed words, everything else tagged with its address.
    assign rom_data = (rom_addr == 32'h0) ? 32'h3C017000 :
                      (rom_addr == 32'h4) ? 32'h3C027000 : (32'hA5000000 | rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2;
        chk("rst_ce", {31'b0, rom_ce}, 32'd0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("e1_ce", {31'b0, rom_ce}, 32'd1);
        chk("e1_pc", rom_addr, 32'h0);
        chk("e1_valid", {31'b0, inst_valid}, 32'd0);
        step();
        chk("e2_inst", inst_o, 32'h3C017000);
        chk("e2_pco", pc_o, 32'h0);
        chk("e2_valid", {31'b0, inst_valid}, 32'd1);
        chk("e2_pc", rom_addr, 32'h4);
        step();
        chk("e3_inst", inst_o, 32'h3C027000);
        chk("e3_pco", pc_o, 32'h4);
        chk("e3_cnt", fetch_cnt, 32'd2);
        chk("e3_pc", rom_addr, 32'h8);

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", rom_addr, 32'h8);
            chk("stall_inst", inst_o, 32'h3C027000);
            chk("stall_pco", pc_o, 32'h4);
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("stall_cnt", fetch_cnt, 32'd2);
        end
        stall = 0;
        step();
        chk("unstall_pc", rom_addr, 32'hC);
        chk("unstall_inst", inst_o, 32'hA5000008);
        chk("unstall_cnt", fetch_cnt, 32'd3);

        step(); step(); step();
        chk("pre_jump_pc", rom_addr, 32'h18);
        jump = 1; jtarget = 32'h10;
        step();
        jump = 0;
        chk("jump_pc", rom_addr, 32'h10);
        chk("jump_valid", {31'b0, inst_valid}, 32'd0);
        chk("jump_pco_hold", pc_o, 32'h14);
        chk("jump_cnt", fetch_cnt, 32'd6);
        step();
        chk("jt_pco", pc_o, 32'h10);
        chk("jt_valid", {31'b0, inst_valid}, 32'd1);
        chk("jt_inst", inst_o, 32'hA5000010);
        chk("jt_cnt", fetch_cnt, 32'd7);

        excpt = 1; br_taken = 1; btarget = 32'h40; stall = 1;
        step();
        excpt = 0; br_taken = 0; stall = 0;
        chk("exc_pc", rom_addr, 32'h50);
        chk("exc_valid", {31'b0, inst_valid}, 32'd0);
        eret = 1; epc = 32'h18;
        step();
        eret = 0;
        chk("eret_pc", rom_addr, 32'h18);
        chk("eret_valid", {31'b0, inst_valid}, 32'd0);
        step();
        chk("post_eret_pco", pc_o, 32'h18);
        chk("post_eret_cnt", fetch_cnt, 32'd8);

        br_taken = 1; btarget = 32'h22;
        step();
        br_taken = 0;
        chk("mis_pc", rom_addr, 32'h20);
        chk("mis_err", {31'b0, addr_err}, 32'd1);
        chk("mis_bad", bad_addr, 32'h22);
        step();
        chk("mis_err_off", {31'b0, addr_err}, 32'd0);
        chk("mis_bad_hold", bad_addr, 32'h22);
        chk("mis_next_pc", rom_addr, 32'h24);
        chk("mis_cnt", fetch_cnt, 32'd9);

        halt = 1;
        step();
        halt = 0; stall = 1; jump = 1; jtarget = 32'h80;
        chk("halt_ce", {31'b0, rom_ce}, 32'd0);
        chk("halt_valid", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_pc", rom_addr, 32'h24);
        end
        chk("halt_ce_end", {31'b0, rom_ce}, 32'd0);
        chk("halt_cnt", fetch_cnt, 32'd9);
        stall = 0; jump = 0; excpt = 1;
        step();
        excpt = 0;
        chk("wake_ce", {31'b0, rom_ce}, 32'd1);
        chk("wake_pc", rom_addr, 32'h50);
        step();
        chk("wake_pco", pc_o, 32'h50);
        chk("wake_valid", {31'b0, inst_valid}, 32'd1);
        chk("wake_cnt", fetch_cnt, 32'd10);

        eret = 1; epc = 32'hFFFFFFFC;
        step();
        eret = 0;
        chk("wrap_pre", rom_addr, 32'hFFFFFFFC);
        step();
        chk("wrap_pc", rom_addr, 32'h0);
        chk("wrap_pco", pc_o, 32'hFFFFFFFC);

        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("arst_ce", {31'b0, rom_ce}, 32'd0);
        chk("arst_pc", rom_addr, 32'h0);
        chk("arst_valid", {31'b0, inst_valid}, 32'd0);
        chk("arst_pco", pc_o, 32'h0);
        chk("arst_bad", bad_addr, 32'h0);
        chk("arst_cnt", fetch_cnt, 32'd0);
        chk("arst_inst", inst_o, 32'h0);

        @(negedge clk);
        rst = 1; jump = 1; jtarget = 32'h40;
        step();
        jump = 0;
        chk("idle_ign_pc", rom_addr, 32'h0);
        chk("idle_ign_ce", {31'b0, rom_ce}, 32'd1);
        chk("idle_ign_valid", {31'b0, inst_valid}, 32'd0);
        step();
        chk("restart_inst", inst_o, 32'h3C017000);
        chk("restart_cnt", fetch_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end
endmodule
